instr_fetch_queue: RTL

//  Instruction queue directly downstream of the I-cache/AXI fetch controller. Captures each fetched
//  {pc, instr} beat presented on write_fifo/fetch_instr_pc and buffers it in a circular FIFO.

---
 rtl/instr_fetch_queue.sv | 81 ++++++++
 1 files changed

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - dual-read instruction FIFO between fetch and a dual-issue decoder
// Circular buffer of {pc, instr} beats with fetch back-pressure, sticky overflow and flush.
module instr_fetch_queue #(
    parameter int DEPTH     = 16,
    parameter int DATA_W    = 64,
    parameter int AF_MARGIN = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       write_fifo,
    input  logic [DATA_W-1:0]          fetch_instr_pc,
    input  logic                       flush,
    input  logic                       dec_ready,
    output logic                       out0_valid,
    output logic [DATA_W-1:0]          out0_data,
    output logic                       out1_valid,
    output logic [DATA_W-1:0]          out1_data,
    output logic                       stop_fetch,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     rd_ptr_p1;
    logic [CW-1:0]     pops;
    logic [CW-1:0]     count_next;
    logic              push_acc;
    logic              stop_next;

    assign rd_ptr_p1  = rd_ptr + PW'(1);
    assign out0_valid = (count >= CW'(1));
    assign out1_valid = (count >= CW'(2));
    assign out0_data  = mem[rd_ptr];
    assign out1_data  = mem[rd_ptr_p1];

    // A full queue still accepts a push when the decoder frees a slot in the same cycle.
    always_comb begin
        pops = '0;
        if (dec_ready) begin
            pops = CW'(out0_valid) + CW'(out1_valid);
        end
        push_acc   = write_fifo && ((count - pops) < CW'(DEPTH));
        count_next = count - pops + CW'(push_acc);
        stop_next  = ((CW'(DEPTH) - count_next) <= CW'(AF_MARGIN));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            stop_fetch <= 1'b0;
            overflow   <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            stop_fetch <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr     <= rd_ptr + PW'(pops);
            count      <= count_next;
            stop_fetch <= stop_next;
            overflow   <= overflow | (write_fifo & ~push_acc);
        end
    end

    // Storage is deliberately left out of reset; valid flags alone qualify the data.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push_acc) begin
            mem[wr_ptr] <= fetch_instr_pc;
        end
    end
endmodule
